// File: rtl/election_bonus_arbiter.sv
// Election-house scheduler plus round-robin bonus arbiter; optional bonusType rotation under BONUS_TYPE_ROTATE_EN.
// Latency: bonus pulse to bonusValid 2 cycles from IDLE; backpressure: offer held stable until bonusAck, counts saturate.
module election_bonus_arbiter #(
    parameter int OPEN_FRAMES    = 900,
    parameter int CLOSED_FRAMES  = 300,
    parameter int HOLDOFF_FRAMES = 2,
    parameter int MAX_PENDING    = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start_of_frame,
    input  logic       tank1Bonus,
    input  logic       tank2Bonus,
    input  logic       bonusAck,
    output logic       houseOpen,
    output logic       bonusValid,
    output logic       bonusTank,
    output logic [1:0] bonusType,
    output logic [1:0] pending1,
    output logic [1:0] pending2
);

    localparam int FMAX = (OPEN_FRAMES > CLOSED_FRAMES) ? OPEN_FRAMES : CLOSED_FRAMES;
    localparam int FW   = $clog2(FMAX + 1);
    localparam int HW   = $clog2(HOLDOFF_FRAMES + 2);

    localparam logic [FW-1:0] OPEN_LAST   = FW'(OPEN_FRAMES - 1);
    localparam logic [FW-1:0] CLOSED_LAST = FW'(CLOSED_FRAMES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLDOFF_FRAMES - 1);
    localparam logic [1:0]    MAX_P       = 2'(MAX_PENDING);

    localparam logic [0:0] H_OPEN   = 1'b0;
    localparam logic [0:0] H_CLOSED = 1'b1;

    localparam logic [1:0] A_IDLE    = 2'd0;
    localparam logic [1:0] A_OFFER   = 2'd1;
    localparam logic [1:0] A_HOLDOFF = 2'd2;

    logic [0:0]    house_state;
    logic [FW-1:0] frame_cnt;
    logic          frame_last;

    logic [1:0]    arb_state;
    logic [HW-1:0] hold_cnt;
    logic          last_served;
    logic          handshake;
    logic          pick;
    logic [1:0]    pending1_nxt;
    logic [1:0]    pending2_nxt;

    // House scheduler: houseOpen lags the state by one register stage.
    assign frame_last = (house_state == H_OPEN) ? (frame_cnt == OPEN_LAST)
                                                : (frame_cnt == CLOSED_LAST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            house_state <= H_OPEN;
            frame_cnt   <= '0;
            houseOpen   <= 1'b0;
        end else begin
            houseOpen <= (house_state == H_OPEN);
            if (start_of_frame) begin
                if (frame_last) begin
                    house_state <= ~house_state;
                    frame_cnt   <= '0;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // bonusValid is only ever high in OFFER, so the handshake implies OFFER.
    assign handshake = bonusValid & bonusAck;

    function automatic logic [1:0] pend_next(input logic [1:0] cur, input logic inc, input logic dec);
        logic [1:0] res;
        res = cur;
        if (inc && !dec && (cur != MAX_P))
            res = cur + 2'd1;
        else if (dec && !inc)
            res = cur - 2'd1;
        return res;
    endfunction

    always_comb begin
        pending1_nxt = pend_next(pending1, tank1Bonus & houseOpen, handshake & ~bonusTank);
        pending2_nxt = pend_next(pending2, tank2Bonus & houseOpen, handshake &  bonusTank);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pending1 <= 2'd0;
            pending2 <= 2'd0;
        end else begin
            pending1 <= pending1_nxt;
            pending2 <= pending2_nxt;
        end
    end

    // Tie goes to the tank not served last; otherwise whichever has a count.
    assign pick = ((|pending1) && (|pending2)) ? ~last_served : ~(|pending1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            arb_state   <= A_IDLE;
            bonusValid  <= 1'b0;
            bonusTank   <= 1'b0;
            last_served <= 1'b1;
            hold_cnt    <= '0;
        end else begin
            case (arb_state)
                A_IDLE: begin
                    if ((|pending1) || (|pending2)) begin
                        bonusTank  <= pick;
                        bonusValid <= 1'b1;
                        arb_state  <= A_OFFER;
                    end
                end
                A_OFFER: begin
                    if (bonusAck) begin
                        bonusValid  <= 1'b0;
                        last_served <= bonusTank;
                        hold_cnt    <= '0;
                        arb_state   <= A_HOLDOFF;
                    end
                end
                A_HOLDOFF: begin
                    if (HOLDOFF_FRAMES == 0) begin
                        arb_state <= A_IDLE;
                    end else if (start_of_frame) begin
                        if (hold_cnt == HOLD_LAST)
                            arb_state <= A_IDLE;
                        else
                            hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: arb_state <= A_IDLE;
            endcase
        end
    end

`ifdef BONUS_TYPE_ROTATE_EN
    logic [1:0] type_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            type_q <= 2'd0;
        else if (handshake)
            type_q <= (type_q == 2'd2) ? 2'd0 : type_q + 2'd1;
    end

    assign bonusType = type_q;
`else
    assign bonusType = 2'd0;
`endif

endmodule

// File: tb/tb_election_bonus_arbiter.sv
// Randomized and directed bench for election_bonus_arbiter against a behavioural model.
module tb_election_bonus_arbiter;

    localparam int OF = 4;
    localparam int CF = 2;
    localparam int HF = 2;
    localparam int MP = 3;
`ifdef BONUS_TYPE_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       start_of_frame = 1'b0;
    logic       tank1Bonus = 1'b0;
    logic       tank2Bonus = 1'b0;
    logic       bonusAck = 1'b0;
    logic       houseOpen;
    logic       bonusValid;
    logic       bonusTank;
    logic [1:0] bonusType;
    logic [1:0] pending1;
    logic [1:0] pending2;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_sofs, m_p1, m_p2, m_mode, m_left, m_type;
    bit m_house, m_valid, m_tank, m_last;

    election_bonus_arbiter #(
        .OPEN_FRAMES(OF), .CLOSED_FRAMES(CF), .HOLDOFF_FRAMES(HF), .MAX_PENDING(MP)
    ) dut (
        .clk(clk), .resetN(resetN), .start_of_frame(start_of_frame),
        .tank1Bonus(tank1Bonus), .tank2Bonus(tank2Bonus), .bonusAck(bonusAck),
        .houseOpen(houseOpen), .bonusValid(bonusValid), .bonusTank(bonusTank),
        .bonusType(bonusType), .pending1(pending1), .pending2(pending2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_sofs = 0; m_p1 = 0; m_p2 = 0; m_mode = 0; m_left = 0; m_type = 0;
        m_house = 1'b0; m_valid = 1'b0; m_tank = 1'b0; m_last = 1'b1;
    endtask

    // House is open when the SOF count lands in the first OF frames of each period.
    function automatic bit house_state_open();
        return (m_sofs % (OF + CF)) < OF;
    endfunction

    function automatic int pend_next(input int c, input bit inc, input bit dec);
        if (inc && dec) return c;
        return ((inc && c < MP) ? c + 1 : c) - (dec ? 1 : 0);
    endfunction

    task automatic model_step(input bit s, input bit i1, input bit i2, input bit a);
        bit hs;
        int n1, n2;
        hs = m_valid && a;
        n1 = pend_next(m_p1, i1 && m_house, hs && !m_tank);
        n2 = pend_next(m_p2, i2 && m_house, hs && m_tank);
        case (m_mode)
            0: if (m_p1 > 0 || m_p2 > 0) begin
                m_tank  = (m_p1 > 0 && m_p2 > 0) ? !m_last : (m_p1 == 0);
                m_valid = 1'b1;
                m_mode  = 1;
            end
            1: if (a) begin
                m_valid = 1'b0;
                m_last  = m_tank;
                if (ROT) m_type = (m_type + 1) % 3;
                m_mode  = 2;
                m_left  = HF;
            end
            default: if (m_left == 0) m_mode = 0;
                     else if (s) begin
                         m_left--;
                         if (m_left == 0) m_mode = 0;
                     end
        endcase
        m_house = house_state_open();
        if (s) m_sofs++;
        m_p1 = n1;
        m_p2 = n2;
    endtask

    task automatic tick(input bit s, input bit i1, input bit i2, input bit a);
        start_of_frame = s; tank1Bonus = i1; tank2Bonus = i2; bonusAck = a;
        @(posedge clk);
        model_step(s, i1, i2, a);
        #1;
        start_of_frame = 0; tank1Bonus = 0; tank2Bonus = 0; bonusAck = 0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
    endtask

    task automatic ensure_open();
        for (int i = 0; i < 12 && !m_house; i++) begin
            tick(1, 0, 0, 0);
            tick(0, 0, 0, 0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            if (m_mode == 0 && m_p1 == 0 && m_p2 == 0) break;
            tick(1, 0, 0, 1);
        end
    endtask

    function automatic logic [8:0] model_vec();
        return {m_house, m_valid, m_tank, 2'(m_type), 2'(m_p1), 2'(m_p2)};
    endfunction

    task automatic test_reset();
        resetN = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({houseOpen, bonusValid, bonusTank, bonusType, pending1, pending2} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", {houseOpen, bonusValid, bonusTank, bonusType, pending1, pending2});
        end
        resetN = 1'b1;
        tick(0, 0, 0, 0);
        checks++;
        if (houseOpen !== 1'b1) begin
            errors++; $display("FAIL reset_house_rise got %b want 1", houseOpen);
        end
    endtask

    task automatic test_tie();
        tick(0, 1, 1, 0);
        checks++;
        if (pending1 !== 2'd1 || pending2 !== 2'd1) begin
            errors++; $display("FAIL tie_counts got %0d/%0d want 1/1", pending1, pending2);
        end
        tick(0, 0, 0, 0);
        checks++;
        if (bonusValid !== 1'b1 || bonusTank !== 1'b0) begin
            errors++; $display("FAIL tie_first got v%b t%b want v1 t0", bonusValid, bonusTank);
        end
        tick(0, 0, 0, 1);
        checks++;
        if (pending1 !== 2'd0 || pending2 !== 2'd1 || bonusValid !== 1'b0) begin
            errors++; $display("FAIL tie_ack got %0d/%0d v%b want 0/1 v0", pending1, pending2, bonusValid);
        end
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        checks++;
        if (bonusValid !== 1'b1 || bonusTank !== 1'b1) begin
            errors++; $display("FAIL tie_second got v%b t%b want v1 t1", bonusValid, bonusTank);
        end
        drain();
    endtask

    task automatic test_single();
        ensure_open();
        tick(0, 1, 0, 0);
        checks++;
        if (pending1 !== 2'd1 || bonusValid !== 1'b0) begin
            errors++; $display("FAIL single_pend got %0d v%b want 1 v0", pending1, bonusValid);
        end
        tick(0, 0, 0, 0);
        checks++;
        if (bonusValid !== 1'b1 || bonusTank !== 1'b0) begin
            errors++; $display("FAIL single_offer got v%b t%b want v1 t0", bonusValid, bonusTank);
        end
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        checks++;
        if (bonusValid !== 1'b1 || bonusTank !== 1'b0 || pending1 !== 2'd1) begin
            errors++; $display("FAIL single_hold got v%b t%b p%0d want v1 t0 p1", bonusValid, bonusTank, pending1);
        end
        tick(0, 0, 0, 1);
        checks++;
        if (pending1 !== 2'd0 || bonusValid !== 1'b0) begin
            errors++; $display("FAIL single_ack got p%0d v%b want p0 v0", pending1, bonusValid);
        end
        drain();
    endtask

    task automatic test_saturation();
        ensure_open();
        repeat (5) tick(0, 0, 1, 0);
        checks++;
        if (pending2 !== 2'd3) begin
            errors++; $display("FAIL saturation got %0d want 3", pending2);
        end
        drain();
    endtask

    task automatic test_house();
        do_reset();
        tick(0, 0, 0, 0);
        repeat (4) tick(1, 0, 0, 0);
        checks++;
        if (houseOpen !== 1'b1) begin
            errors++; $display("FAIL house_still_open got %b want 1", houseOpen);
        end
        tick(0, 0, 0, 0);
        checks++;
        if (houseOpen !== 1'b0) begin
            errors++; $display("FAIL house_close got %b want 0", houseOpen);
        end
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        checks++;
        if (pending1 !== 2'd0 || bonusValid !== 1'b0) begin
            errors++; $display("FAIL house_closed_pulse got p%0d v%b want p0 v0", pending1, bonusValid);
        end
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        checks++;
        if (houseOpen !== 1'b1) begin
            errors++; $display("FAIL house_reopen got %b want 1", houseOpen);
        end
    endtask

    task automatic test_reset_mid_offer();
        ensure_open();
        tick(0, 1, 1, 0);
        tick(0, 0, 0, 0);
        checks++;
        if (bonusValid !== 1'b1) begin
            errors++; $display("FAIL midoffer_setup got v%b want 1", bonusValid);
        end
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (bonusValid !== 1'b0 || pending1 !== 2'd0 || pending2 !== 2'd0 || houseOpen !== 1'b0) begin
            errors++; $display("FAIL midoffer_async got v%b p%0d/%0d h%b want all 0", bonusValid, pending1, pending2, houseOpen);
        end
        model_reset();
        @(posedge clk);
        #1 resetN = 1'b1;
        tick(0, 0, 0, 0);
    endtask

    task automatic test_rotation();
        do_reset();
        tick(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            ensure_open();
            tick(0, 1, 0, 0);
            for (int i = 0; i < 10 && bonusValid !== 1'b1; i++) tick(0, 0, 0, 0);
            checks++;
            if (bonusValid !== 1'b1) begin
                errors++; $display("FAIL rotation_timeout k%0d got v%b want 1", k, bonusValid);
            end
            checks++;
            if (bonusType !== (ROT ? 2'(k % 3) : 2'd0)) begin
                errors++; $display("FAIL rotation_type k%0d got %0d want %0d", k, bonusType, ROT ? k % 3 : 0);
            end
            tick(0, 0, 0, 1);
            drain();
        end
    endtask

    task automatic test_random();
        bit s, i1, i2, a;
        for (int n = 0; n < 600; n++) begin
            s  = ($urandom_range(3) == 0);
            i1 = ($urandom_range(2) == 0);
            i2 = ($urandom_range(2) == 0);
            a  = ($urandom_range(1) == 0);
            tick(s, i1, i2, a);
            checks++;
            if ({houseOpen, bonusValid, bonusTank, bonusType, pending1, pending2} !== model_vec()) begin
                errors++;
                $display("FAIL random cyc%0d got %b want %b", n,
                         {houseOpen, bonusValid, bonusTank, bonusType, pending1, pending2}, model_vec());
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_saturation();
        test_house();
        test_reset_mid_offer();
        test_rotation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
